cmx_twiddle_mul: RTL and testbench

Pipelined complex twiddle multiplier, placed directly downstream of the DIF butterfly add/subtract stage. It takes the butterfly's difference output and multiplies it by a Q1.15 twiddle factor W. It rounds and saturates the result back to 16-bit real/imag and presents it with a valid/ready handshake. It also counts output samples per FFT frame and flags the last sample of each frame for the next stage.

---
 rtl/cmx_twiddle_mul.sv | 73 +++++++
 tb/tb_cmx_twiddle_mul.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/cmx_twiddle_mul.sv
// cmx_twiddle_mul: 3-stage complex multiply by a Q1.15 twiddle with round/saturate,
// valid/ready backpressure and a per-frame last-sample flag.
module cmx_twiddle_mul #(
   parameter int LOG2N = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] w,
   input  logic        bypass,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] c,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last
);
   logic              en, v1, v2, b1, b2;
   logic [31:0]       a1, w1, a2;
   logic signed [15:0] ar, ai, wr, wi;
   logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [32:0] re, im;
   logic [15:0]       re_s, im_s;
   logic [LOG2N-1:0]  cnt, idx;

   function automatic logic [15:0] rnd_sat(input logic signed [32:0] x);
      logic signed [32:0] y;
      y = (x + 33'sd16384) >>> 15;
      return y > 33'sd32767 ? 16'h7fff : y < -33'sd32768 ? 16'h8000 : y[15:0];
   endfunction

   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign ar       = a1[15:0];
   assign ai       = a1[31:16];
   assign wr       = w1[15:0];
   assign wi       = w1[31:16];
   assign re       = 33'(p_rr) - 33'(p_ii);
   assign im       = 33'(p_ri) + 33'(p_ir);
   assign re_s     = rnd_sat(re);
   assign im_s     = rnd_sat(im);
   // index of the sample entering S3: the one in S3 now is leaving if out_valid
   assign idx      = cnt + LOG2N'(out_valid);

   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         cnt       <= '0;
         c         <= '0;
      end else begin
         if (out_valid && out_ready) cnt <= cnt + LOG2N'(1);
         if (en) begin
            v1        <= in_valid;
            a1        <= a;
            w1        <= w;
            b1        <= bypass;
            v2        <= v1;
            a2        <= a1;
            b2        <= b1;
            p_rr      <= 32'(ar) * 32'(wr);
            p_ii      <= 32'(ai) * 32'(wi);
            p_ri      <= 32'(ar) * 32'(wi);
            p_ir      <= 32'(ai) * 32'(wr);
            out_valid <= v2;
            out_last  <= v2 && (idx == '1);
            c         <= b2 ? a2 : {im_s, re_s};
         end
      end
   end
endmodule

// File: tb/tb_cmx_twiddle_mul.sv
// tb_cmx_twiddle_mul: directed and randomized-backpressure bench with an in-order scoreboard.
module tb_cmx_twiddle_mul;
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] a = '0, w = '0;
   logic        bypass = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid, out_last;
   logic [31:0] c;

   typedef struct packed { logic [31:0] c; logic last; } exp_t;
   exp_t q[$];
   int errors = 0, checks = 0, pcount = 0, nout = 0, nlast = 0;
   logic        stall_prev = 1'b0, last_prev = 1'b0;
   logic [31:0] c_prev = '0;

   cmx_twiddle_mul #(.LOG2N(4)) dut (
      .clk(clk), .rst(rst), .a(a), .w(w), .bypass(bypass), .in_valid(in_valid),
      .in_ready(in_ready), .c(c), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] sat(longint x);
      longint y;
      y = (x + 64'sd16384) >>> 15;
      if (y > 32767) return 16'h7fff;
      if (y < -32768) return 16'h8000;
      return y[15:0];
   endfunction

   function automatic logic [31:0] model(logic [31:0] av, logic [31:0] wv, logic bv);
      longint ar, ai, wr, wi;
      ar = longint'($signed(av[15:0]));
      ai = longint'($signed(av[31:16]));
      wr = longint'($signed(wv[15:0]));
      wi = longint'($signed(wv[31:16]));
      if (bv) return av;
      return {sat(ar * wi + ai * wr), sat(ar * wr - ai * wi)};
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(logic iv, logic [31:0] av, logic [31:0] wv, logic bv, logic ordy);
      @(negedge clk);
      in_valid = iv; a = av; w = wv; bypass = bv; out_ready = ordy;
      #1;
      if (in_valid && in_ready) begin
         q.push_back({model(av, wv, bv), pcount % 16 == 15});
         pcount++;
      end
   endtask

   task automatic idle(logic ordy);
      step(1'b0, '0, '0, 1'b0, ordy);
   endtask

   task automatic send_chk(string tag, logic [31:0] av, logic [31:0] wv, logic bv, logic [31:0] exp);
      step(1'b1, av, wv, bv, 1'b1);
      idle(1'b1);
      chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
      idle(1'b1);
      chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
      idle(1'b1);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk(tag, c, exp);
   endtask

   always @(negedge clk) begin
      #2;
      if (rst) stall_prev = 1'b0;
      else begin
         chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
         if (stall_prev) begin
            chk("stall_c", c, c_prev);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_last", 32'(out_last), 32'(last_prev));
         end
         if (out_valid && out_ready) begin
            checks++;
            assert (q.size() != 0) else begin
               errors++;
               $error("FAIL sb_underflow: got output %h expected none", c);
            end
            if (q.size() != 0) begin
               exp_t e;
               e = q.pop_front();
               chk("sb_c", c, e.c);
               chk("sb_last", 32'(out_last), 32'(e.last));
            end
            nout++;
            if (out_last) nlast++;
         end
         stall_prev = out_valid && !out_ready;
         c_prev = c;
         last_prev = out_last;
      end
   end

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_c", c, 32'h0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      send_chk("rot_mj", 32'h0000_4000, 32'h8000_0000, 1'b0, 32'hC000_0000);
      send_chk("sat", 32'h8000_8000, 32'h8000_8000, 1'b0, 32'h7FFF_0000);
      send_chk("rnd_pos", 32'h0000_0001, 32'h0000_4000, 1'b0, 32'h0000_0001);
      send_chk("rnd_neg", 32'h0000_FFFF, 32'h0000_4000, 1'b0, 32'h0000_0000);
      send_chk("bypass", 32'h8000_7FFF, 32'h1234_5678, 1'b1, 32'h8000_7FFF);
      for (int k = 0; k < 2000 && pcount < 32; k++)
         step(1'b1, $urandom, $urandom, ($urandom % 8) == 0, 1'($urandom % 2));
      for (int k = 0; k < 500 && q.size() != 0; k++) idle(1'($urandom % 2));
      idle(1'b1);
      chk("drain", q.size(), 32'd0);
      chk("nout", nout, 32'd32);
      chk("nlast", nlast, 32'd2);
      for (int k = 0; k < 3; k++) step(1'b1, $urandom, $urandom, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      q.delete();
      pcount = 0;
      @(negedge clk);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_c", c, 32'h0);
      chk("mid_rst_last", 32'(out_last), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      nout = 0; nlast = 0;
      for (int k = 0; k < 16; k++) step(1'b1, $urandom, $urandom, 1'b0, 1'b1);
      for (int k = 0; k < 50 && q.size() != 0; k++) idle(1'b1);
      idle(1'b1);
      chk("post_rst_drain", q.size(), 32'd0);
      chk("post_rst_nout", nout, 32'd16);
      chk("post_rst_nlast", nlast, 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
